ram_word_hex_uart: RTL and testbench
====================================

Name: ram_word_hex_uart

Overview:
- Downstream consumer of RAM readout data. Accepts one 16-bit word per valid/ready handshake.
- Renders the word as four uppercase ASCII hex characters, optionally followed by CR LF.
- Serialises each character as UART 8N1 on uart_TX.
- Lets RAM dump logic stream result words to a terminal without handling byte framing or baud timing.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit; legal range >= 2 (434 = 50 MHz / 115200).
- APPEND_CRLF, 1, 1 = send 0x0D 0x0A after the four hex chars; 0 = hex chars only.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- word_in  input  16  word to print, sampled on the accepting edge
- word_valid  input  1  word_in is valid
- word_ready  output  1  block can accept a word; equals (state==IDLE) && !reset
- uart_TX  output  1  serial line, idle high, registered
- busy  output  1  high from the cycle after acceptance until return to IDLE
- tx_done  output  1  one-cycle pulse, first IDLE cycle after the final stop bit

Behaviour:
- Reset (synchronous, active-high):
  - Next edge forces uart_TX=1, busy=0, tx_done=0, state IDLE.
  - Clears all counters and the captured word.
  - word_ready is 0 while reset is high.
- Reset mid-frame:
  - Frame is truncated and uart_TX returns high at the next edge.
  - The in-flight word is discarded, with no tx_done.
- Handshake:
  - A word is accepted on a rising edge where word_valid && word_ready.
  - word_in is captured into a 16-bit holding register at that edge.
  - word_valid while busy is ignored; it is neither queued nor acknowledged.
- States: IDLE, START, DATA, STOP.
  - IDLE -> START on accept.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> START (next char) or IDLE (last char) after CLKS_PER_BIT cycles.
- Line timing:
  - uart_TX=0 for exactly CLKS_PER_BIT cycles starting the cycle after acceptance.
  - 8 data bits follow LSB first, each exactly CLKS_PER_BIT cycles.
  - The stop bit is uart_TX=1 for CLKS_PER_BIT cycles.
  - Characters within a word are back-to-back, with no idle gap between frames.
- Character order:
  - Nibbles [15:12], [11:8], [7:4], [3:0].
  - Then 0x0D, 0x0A if APPEND_CRLF=1.
  - Char count N = 6 (APPEND_CRLF=1) or 4 (APPEND_CRLF=0).
- Hex encoding:
  - Nibble 0..9 -> 0x30..0x39.
  - Nibble 10..15 -> 0x41..0x46 (uppercase).
- Latency:
  - Accepting edge to tx_done = 10*N*CLKS_PER_BIT + 1 cycles.
  - tx_done, word_ready=1 and busy=0 occur in the same cycle.
- Back-to-back words: with word_valid held high, the next word is accepted in the tx_done cycle. The line is high for exactly CLKS_PER_BIT+1 cycles between the last stop bit start and the next start bit.
- Counters:
  - Baud counter counts 0..CLKS_PER_BIT-1 and wraps on each bit boundary.
  - Bit index counts 0..7.
  - Char index counts 0..N-1.
  - Widths use $clog2 and must not overflow at maximum values.
- Simultaneous events: reset has priority over acceptance. When reset and word_valid are both high, nothing is accepted.

Test Plan:
1. CLKS_PER_BIT=4, APPEND_CRLF=1, word_in=0x1234 pulsed valid:
   - Decode chars 0x31,0x32,0x33,0x34,0x0D,0x0A.
   - Each frame is 40 cycles; tx_done occurs 241 cycles after accept.
2. word_in=0xABCD, then 0x0000, then 0xFFFF:
   - 0xABCD -> 0x41,0x42,0x43,0x44.
   - 0x0000 -> four 0x30.
   - 0xFFFF -> four 0x46.
3. word_valid held high with words 0x00FF then 0x9A5E:
   - Second word is accepted in the tx_done cycle.
   - Line is high CLKS_PER_BIT+1 cycles between words.
   - Output is "00FF\r\n9A5E\r\n".
4. Valid pulse at 0x1111 while busy during the third char of 0x2222:
   - Only "2222\r\n" is emitted.
   - word_ready stays 0 throughout.
5. Reset asserted for one cycle mid-DATA of the second char:
   - uart_TX=1 and busy=0 at the next edge, with no tx_done.
   - A subsequent word 0x0001 prints correctly.
6. APPEND_CRLF=0, CLKS_PER_BIT=2, word_in=0xC0DE:
   - Emits 0x43,0x30,0x44,0x45.
   - tx_done occurs 81 cycles after accept.

Source files
------------

// File: rtl/ram_word_hex_uart.sv
// Prints each accepted 16-bit word as four uppercase ASCII hex characters
// (optionally followed by CR LF) on a UART 8N1 transmit line.
module ram_word_hex_uart #(
  parameter int CLKS_PER_BIT = 434,
  parameter bit APPEND_CRLF  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        uart_TX,
  output logic        busy,
  output logic        tx_done
);

  localparam int NCHARS = APPEND_CRLF ? 6 : 4;
  localparam int BW     = $clog2(CLKS_PER_BIT);
  localparam int CW     = $clog2(NCHARS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CHAR_LAST = CW'(NCHARS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [CW-1:0] char_idx;
  logic [15:0]   word_q;
  logic [3:0]    nibble;
  logic [7:0]    cur_char;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Character currently on the line, selected from the held word by char_idx.
  always_comb begin
    nibble   = 4'h0;
    cur_char = 8'h0D;
    case (char_idx)
      CW'(0):  nibble = word_q[15:12];
      CW'(1):  nibble = word_q[11:8];
      CW'(2):  nibble = word_q[7:4];
      CW'(3):  nibble = word_q[3:0];
      default: nibble = 4'h0;
    endcase
    if (int'(char_idx) < 4)       cur_char = hex_ascii(nibble);
    else if (int'(char_idx) == 4) cur_char = 8'h0D;
    else                          cur_char = 8'h0A;
  end

  // Handshake: a word transfers on a rising edge where word_valid && word_ready;
  // word_ready is high only in IDLE outside reset, and valid while busy is dropped.
  assign word_ready = (state == IDLE) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      uart_TX  <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      char_idx <= '0;
      word_q   <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (word_valid && word_ready) begin
            word_q   <= word_in;
            state    <= START;
            uart_TX  <= 1'b0;
            busy     <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            char_idx <= '0;
          end
        end
        START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            uart_TX  <= cur_char[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              uart_TX <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              uart_TX <= cur_char[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (char_idx == CHAR_LAST) begin
              state    <= IDLE;
              busy     <= 1'b0;
              tx_done  <= 1'b1;
              char_idx <= '0;
            end else begin
              char_idx <= char_idx + 1'b1;
              state    <= START;
              uart_TX  <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_word_hex_uart.sv
// Bench for ram_word_hex_uart: one instance with CR LF at 4 clocks/bit and one
// without at 2 clocks/bit, each watched by a UART line decoder.
module tb_ram_word_hex_uart;

  localparam int CPB_A = 4;
  localparam int CPB_B = 2;
  localparam int LAT_A = 10 * 6 * CPB_A + 1;
  localparam int LAT_B = 10 * 4 * CPB_B + 1;
  localparam int LIMIT = 400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, valid_a, ready_a, tx_a, busy_a, done_a;
  logic [15:0] word_a;
  logic        rst_b, valid_b, ready_b, tx_b, busy_b, done_b;
  logic [15:0] word_b;

  ram_word_hex_uart #(.CLKS_PER_BIT(CPB_A), .APPEND_CRLF(1'b1)) dut_a (
    .clk(clk), .reset(rst_a), .word_in(word_a), .word_valid(valid_a),
    .word_ready(ready_a), .uart_TX(tx_a), .busy(busy_a), .tx_done(done_a));

  ram_word_hex_uart #(.CLKS_PER_BIT(CPB_B), .APPEND_CRLF(1'b0)) dut_b (
    .clk(clk), .reset(rst_b), .word_in(word_b), .word_valid(valid_b),
    .word_ready(ready_b), .uart_TX(tx_b), .busy(busy_b), .tx_done(done_b));

  typedef struct {
    logic [15:0] word;
    logic [47:0] chars;
    int          lat;
  } vec_t;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b[$];
  logic [7:0] rx_a[$];
  logic [7:0] rx_b[$];
  int         gap_a[$];
  int         fr_err_a = 0;
  int         fr_err_b = 0;
  int         rdy_err  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: format the word as text and uppercase it; CR LF in the low bytes.
  function automatic logic [47:0] model_chars(input logic [15:0] w);
    string       s;
    logic [47:0] r;
    logic [7:0]  c;
    s = $sformatf("%04h", w);
    r = {32'd0, 8'h0D, 8'h0A};
    for (int i = 0; i < 4; i++) begin
      c = s.getc(i);
      if (c >= 8'h61) c = c - 8'h20;
      r[47-8*i -: 8] = c;
    end
    return r;
  endfunction

  // Line decoders: every bit must hold for exactly CPB samples, stop bit high.
  bit         ma_active = 1'b0;
  int         ma_k, ma_b, ma_gap = 0;
  logic       ma_cur;
  logic [7:0] ma_byte;
  always @(negedge clk) begin
    if (rst_a) begin
      ma_active = 1'b0;
      ma_gap    = 0;
    end else begin
      if (!ma_active) begin
        if (tx_a == 1'b0) begin
          ma_active = 1'b1;
          ma_k      = 0;
          gap_a.push_back(ma_gap);
          ma_gap    = 0;
        end else ma_gap++;
      end
      if (ma_active) begin
        ma_b = ma_k / CPB_A;
        if (ma_k % CPB_A == 0) begin
          ma_cur = tx_a;
          if (ma_b >= 1 && ma_b <= 8) ma_byte[ma_b-1] = tx_a;
          if (ma_b == 9 && tx_a !== 1'b1) fr_err_a++;
        end else if (tx_a !== ma_cur) fr_err_a++;
        ma_k++;
        if (ma_k == 10 * CPB_A) begin
          ma_active = 1'b0;
          rx_a.push_back(ma_byte);
        end
      end
    end
  end

  bit         mb_active = 1'b0;
  int         mb_k, mb_b;
  logic       mb_cur;
  logic [7:0] mb_byte;
  always @(negedge clk) begin
    if (rst_b) mb_active = 1'b0;
    else begin
      if (!mb_active && tx_b == 1'b0) begin
        mb_active = 1'b1;
        mb_k      = 0;
      end
      if (mb_active) begin
        mb_b = mb_k / CPB_B;
        if (mb_k % CPB_B == 0) begin
          mb_cur = tx_b;
          if (mb_b >= 1 && mb_b <= 8) mb_byte[mb_b-1] = tx_b;
          if (mb_b == 9 && tx_b !== 1'b1) fr_err_b++;
        end else if (tx_b !== mb_cur) fr_err_b++;
        mb_k++;
        if (mb_k == 10 * CPB_B) begin
          mb_active = 1'b0;
          rx_b.push_back(mb_byte);
        end
      end
    end
  end

  task automatic push_a(input logic [47:0] c);
    for (int i = 0; i < 6; i++) exp_q.push_back(c[47-8*i -: 8]);
  endtask

  task automatic push_b(input logic [47:0] c);
    for (int i = 0; i < 4; i++) exp_b.push_back(c[47-8*i -: 8]);
  endtask

  // Offer a word to dut_a, then watch until tx_done (lat = negedges after the
  // accepting edge, 0 if none). inj_at/rst_at inject a busy-time valid or a reset.
  task automatic send_a(input logic [15:0] w, input bit hold, input int inj_at,
                        input int rst_at, output int lat);
    int wait_n;
    wait_n = 0;
    while (ready_a !== 1'b1 && wait_n < LIMIT) begin
      @(negedge clk);
      wait_n++;
    end
    check("ready_before_send_a", 32'(ready_a), 32'd1);
    word_a  = w;
    valid_a = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) valid_a = 1'b0;
    lat = 0;
    for (int n = 1; n <= LIMIT; n++) begin
      @(negedge clk);
      if (n == 1) check("busy_after_accept_a", 32'(busy_a), 32'd1);
      if (n == inj_at) begin
        word_a  = 16'h1111;
        valid_a = 1'b1;
      end
      if (n == inj_at + 1) valid_a = 1'b0;
      if (n == rst_at) rst_a = 1'b1;
      if (n == rst_at + 1) begin
        rst_a = 1'b0;
        check("tx_after_reset", 32'(tx_a), 32'd1);
        check("busy_after_reset", 32'(busy_a), 32'd0);
        check("done_after_reset", 32'(done_a), 32'd0);
      end
      if (done_a === 1'b1) begin
        lat = n;
        check("ready_at_done_a", 32'(ready_a), 32'd1);
        check("busy_at_done_a", 32'(busy_a), 32'd0);
        break;
      end
      if (rst_at < 0 && ready_a !== 1'b0) rdy_err++;
    end
  endtask

  task automatic send_b(input logic [15:0] w, output int lat);
    int wait_n;
    wait_n = 0;
    while (ready_b !== 1'b1 && wait_n < LIMIT) begin
      @(negedge clk);
      wait_n++;
    end
    check("ready_before_send_b", 32'(ready_b), 32'd1);
    word_b  = w;
    valid_b = 1'b1;
    @(posedge clk);
    #1;
    valid_b = 1'b0;
    lat = 0;
    for (int n = 1; n <= LIMIT; n++) begin
      @(negedge clk);
      if (n == 1) check("busy_after_accept_b", 32'(busy_b), 32'd1);
      if (done_b === 1'b1) begin
        lat = n;
        check("busy_at_done_b", 32'(busy_b), 32'd0);
        break;
      end
    end
  endtask

  task automatic drain_a(input string tag);
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rx_a.size() == 0) check({tag, "_missing"}, 32'hFFFF, {24'd0, e});
      else check(tag, {24'd0, rx_a.pop_front()}, {24'd0, e});
    end
    check({tag, "_extra"}, rx_a.size(), 32'd0);
  endtask

  task automatic drain_b(input string tag);
    logic [7:0] e;
    while (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      if (rx_b.size() == 0) check({tag, "_missing"}, 32'hFFFF, {24'd0, e});
      else check(tag, {24'd0, rx_b.pop_front()}, {24'd0, e});
    end
    check({tag, "_extra"}, rx_b.size(), 32'd0);
  endtask

  initial begin
    vec_t        vecs[6];
    int          lat;
    int          sum;
    logic [47:0] e5;
    logic [15:0] rw;

    vecs[0] = '{16'h1234, {"1234", 8'h0D, 8'h0A}, LAT_A};
    vecs[1] = '{16'hABCD, {"ABCD", 8'h0D, 8'h0A}, LAT_A};
    vecs[2] = '{16'h0000, {"0000", 8'h0D, 8'h0A}, LAT_A};
    vecs[3] = '{16'hFFFF, {"FFFF", 8'h0D, 8'h0A}, LAT_A};
    vecs[4] = '{16'h00FF, {"00FF", 8'h0D, 8'h0A}, LAT_A};
    vecs[5] = '{16'h9A5E, {"9A5E", 8'h0D, 8'h0A}, LAT_A};

    // Reset with valid high: nothing may be accepted, line idle.
    rst_a = 1'b1; valid_a = 1'b1; word_a = 16'hFFFF;
    rst_b = 1'b1; valid_b = 1'b0; word_b = 16'h0000;
    repeat (3) begin
      @(negedge clk);
      check("ready_in_reset", 32'(ready_a), 32'd0);
      check("busy_in_reset", 32'(busy_a), 32'd0);
    end
    check("tx_in_reset", 32'(tx_a), 32'd1);
    check("done_in_reset", 32'(done_a), 32'd0);
    rst_a = 1'b0; valid_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    check("busy_after_release", 32'(busy_a), 32'd0);
    check("ready_after_release", 32'(ready_a), 32'd1);

    for (int i = 0; i < 4; i++) begin
      push_a(vecs[i].chars);
      send_a(vecs[i].word, 1'b0, -1, -1, lat);
      check("latency_table", lat, vecs[i].lat);
      drain_a("chars_table");
    end

    // Back-to-back words with valid held high.
    gap_a.delete();
    push_a(vecs[4].chars);
    push_a(vecs[5].chars);
    send_a(vecs[4].word, 1'b1, -1, -1, lat);
    check("latency_b2b_first", lat, LAT_A);
    send_a(vecs[5].word, 1'b0, -1, -1, lat);
    check("latency_b2b_second", lat, LAT_A);
    drain_a("chars_b2b");
    check("gap_count", gap_a.size(), 32'd12);
    if (gap_a.size() == 12) begin
      check("gap_between_words", gap_a[6], 32'd1);
      sum = 0;
      for (int i = 1; i < 12; i++) if (i != 6) sum += gap_a[i];
      check("gap_within_words", sum, 32'd0);
    end

    // A valid pulse during the third character must be ignored.
    push_a(model_chars(16'h2222));
    send_a(16'h2222, 1'b0, 100, -1, lat);
    check("latency_busy_pulse", lat, LAT_A);
    drain_a("chars_busy_pulse");
    repeat (60) @(negedge clk);
    check("no_queued_word_busy", 32'(busy_a), 32'd0);
    check("no_queued_word_chars", rx_a.size(), 32'd0);
    check("ready_low_while_busy", rdy_err, 32'd0);

    // Reset in the data bits of the second character.
    e5 = model_chars(16'h5A5A);
    exp_q.push_back(e5[47:40]);
    send_a(16'h5A5A, 1'b0, -1, 55, lat);
    check("no_done_after_reset", lat, 32'd0);
    drain_a("chars_truncated");
    push_a(model_chars(16'h0001));
    send_a(16'h0001, 1'b0, -1, -1, lat);
    check("latency_after_reset", lat, LAT_A);
    drain_a("chars_after_reset");

    for (int i = 0; i < 6; i++) begin
      rw = 16'($urandom_range(0, 16'hFFFF));
      push_a(model_chars(rw));
      send_a(rw, 1'b0, -1, -1, lat);
      check("latency_rand_a", lat, LAT_A);
      drain_a("chars_rand_a");
    end

    // Hex-only instance at 2 clocks per bit.
    push_b({"C0DE", 16'h0000});
    send_b(16'hC0DE, lat);
    check("latency_c0de", lat, LAT_B);
    drain_b("chars_c0de");
    for (int i = 0; i < 4; i++) begin
      rw = 16'($urandom_range(0, 16'hFFFF));
      push_b(model_chars(rw));
      send_b(rw, lat);
      check("latency_rand_b", lat, LAT_B);
      drain_b("chars_rand_b");
    end

    check("framing_a", fr_err_a, 32'd0);
    check("framing_b", fr_err_b, 32'd0);
    check("rdy_low_all", rdy_err, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
